// File: rtl/hamming_secded_stream_decoder_if.sv
// Stream and statistics bundle for the SECDED stream decoder.
// The master side drives words and out_ready; the slave side (the decoder) returns results.
interface hamming_secded_stream_decoder_if #(
    parameter int unsigned R  = 3,
    parameter int unsigned CW = 16
);
    localparam int unsigned N = 2 ** R;
    localparam int unsigned K = N - 1 - R;

    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_code;
    logic          correct_en;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_code;
    logic [K-1:0]  out_data;
    logic [R-1:0]  out_syndrome;
    logic          out_sec;
    logic          out_ded;
    logic          clr_cnt;
    logic [CW-1:0] cnt_sec;
    logic [CW-1:0] cnt_ded;

    modport master (
        output in_valid, in_code, correct_en, out_ready, clr_cnt,
        input  in_ready, out_valid, out_code, out_data, out_syndrome, out_sec, out_ded,
               cnt_sec, cnt_ded
    );

    modport slave (
        input  in_valid, in_code, correct_en, out_ready, clr_cnt,
        output in_ready, out_valid, out_code, out_data, out_syndrome, out_sec, out_ded,
               cnt_sec, cnt_ded
    );
endinterface

// File: rtl/hamming_secded_stream_decoder.sv
// Two-stage extended-Hamming (SECDED) decoder with valid/ready flow control
// and saturating single/double error counters.
module hamming_secded_stream_decoder #(
    parameter int unsigned R  = 3,
    parameter int unsigned CW = 16
) (
    input logic                            clk_i,
    input logic                            rst_i,
    hamming_secded_stream_decoder_if.slave strm_io
);
    localparam int unsigned N = 2 ** R;
    localparam int unsigned K = N - 1 - R;

    logic          en;
    logic          handshake;

    logic          s1_valid_q, s1_valid_d;
    logic [N-1:0]  s1_code_q, s1_code_d;
    logic          s1_cen_q, s1_cen_d;
    logic [R-1:0]  s1_syn_q, s1_syn_d;
    logic          s1_pe_q, s1_pe_d;

    logic          out_valid_q, out_valid_d;
    logic [N-1:0]  out_code_q, out_code_d;
    logic [K-1:0]  out_data_q, out_data_d;
    logic [R-1:0]  out_syn_q, out_syn_d;
    logic          out_sec_q, out_sec_d;
    logic          out_ded_q, out_ded_d;

    logic [CW-1:0] cnt_sec_q, cnt_sec_d;
    logic [CW-1:0] cnt_ded_q, cnt_ded_d;

    logic [R-1:0]  in_syn;
    logic          in_pe;
    logic [R-1:0]  flip_idx;
    logic [N-1:0]  corr_code;
    logic [K-1:0]  corr_data;

    assign en        = strm_io.out_ready | ~out_valid_q;
    assign handshake = out_valid_q & strm_io.out_ready;

    always_comb begin
        in_syn = '0;
        for (int unsigned p = 1; p < N; p++) begin
            if (strm_io.in_code[p-1]) in_syn = in_syn ^ R'(p);
        end
        in_pe = ^strm_io.in_code;
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_code_d  = s1_code_q;
        s1_cen_d   = s1_cen_q;
        s1_syn_d   = s1_syn_q;
        s1_pe_d    = s1_pe_q;
        if (en) begin
            s1_valid_d = strm_io.in_valid;
            if (strm_io.in_valid) begin
                s1_code_d = strm_io.in_code;
                s1_cen_d  = strm_io.correct_en;
                s1_syn_d  = in_syn;
                s1_pe_d   = in_pe;
            end
        end
    end

    // Zero syndrome with a parity error means the overall parity bit itself flipped.
    always_comb begin : correct_extract
        int unsigned k;
        corr_code = s1_code_q;
        flip_idx  = (s1_syn_q == '0) ? R'(N - 1) : s1_syn_q - R'(1);
        if (s1_pe_q && s1_cen_q) corr_code[flip_idx] = ~corr_code[flip_idx];
        corr_data = '0;
        k         = 0;
        for (int unsigned p = 1; p < N; p++) begin
            if ((p & (p - 1)) != 0) begin
                corr_data[k] = corr_code[p-1];
                k            = k + 1;
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_code_d  = out_code_q;
        out_data_d  = out_data_q;
        out_syn_d   = out_syn_q;
        out_sec_d   = out_sec_q;
        out_ded_d   = out_ded_q;
        if (en) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_code_d = corr_code;
                out_data_d = corr_data;
                out_syn_d  = s1_syn_q;
                out_sec_d  = s1_pe_q;
                out_ded_d  = ~s1_pe_q & (s1_syn_q != '0);
            end
        end
    end

    // Clear takes priority over a same-cycle increment.
    always_comb begin
        cnt_sec_d = cnt_sec_q;
        cnt_ded_d = cnt_ded_q;
        if (strm_io.clr_cnt) begin
            cnt_sec_d = '0;
            cnt_ded_d = '0;
        end else begin
            if (handshake && out_sec_q && (cnt_sec_q != '1)) cnt_sec_d = cnt_sec_q + CW'(1);
            if (handshake && out_ded_q && (cnt_ded_q != '1)) cnt_ded_d = cnt_ded_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q  <= 1'b0;
            s1_code_q   <= '0;
            s1_cen_q    <= 1'b0;
            s1_syn_q    <= '0;
            s1_pe_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_code_q  <= '0;
            out_data_q  <= '0;
            out_syn_q   <= '0;
            out_sec_q   <= 1'b0;
            out_ded_q   <= 1'b0;
            cnt_sec_q   <= '0;
            cnt_ded_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_code_q   <= s1_code_d;
            s1_cen_q    <= s1_cen_d;
            s1_syn_q    <= s1_syn_d;
            s1_pe_q     <= s1_pe_d;
            out_valid_q <= out_valid_d;
            out_code_q  <= out_code_d;
            out_data_q  <= out_data_d;
            out_syn_q   <= out_syn_d;
            out_sec_q   <= out_sec_d;
            out_ded_q   <= out_ded_d;
            cnt_sec_q   <= cnt_sec_d;
            cnt_ded_q   <= cnt_ded_d;
        end
    end

    assign strm_io.in_ready     = en;
    assign strm_io.out_valid    = out_valid_q;
    assign strm_io.out_code     = out_code_q;
    assign strm_io.out_data     = out_data_q;
    assign strm_io.out_syndrome = out_syn_q;
    assign strm_io.out_sec      = out_sec_q;
    assign strm_io.out_ded      = out_ded_q;
    assign strm_io.cnt_sec      = cnt_sec_q;
    assign strm_io.cnt_ded      = cnt_ded_q;
endmodule

// File: tb/tb_hamming_secded_stream_decoder.sv
// Scoreboard bench: R=3 main stream, R=3/CW=2 counter saturation, R=4 exhaustive sweep.
module tb_hamming_secded_stream_decoder;
    typedef struct {
        logic [15:0] code;
        logic [10:0] data;
        logic [3:0]  syn;
        logic        sec;
        logic        ded;
        logic        chk_data;
        logic        chk_lat;
        int          cyc;
    } exp_t;

    localparam logic [7:0] VCODE [8] = '{8'h55, 8'h75, 8'h75, 8'hD5, 8'h74, 8'hD5, 8'h00, 8'h01};
    localparam logic       VCEN  [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    localparam logic [7:0] VEXC  [8] = '{8'h55, 8'h55, 8'h75, 8'h55, 8'h74, 8'hD5, 8'h00, 8'h00};
    localparam logic [3:0] VDAT  [8] = '{4'hB, 4'hB, 4'hF, 4'hB, 4'hF, 4'hB, 4'h0, 4'h0};
    localparam logic [2:0] VSYN  [8] = '{3'd0, 3'd6, 3'd6, 3'd0, 3'd7, 3'd0, 3'd0, 3'd1};
    localparam logic       VSEC  [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    localparam logic       VDED  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   bp_en = 1'b0;
    exp_t q1[$];
    exp_t q3[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    hamming_secded_stream_decoder_if #(.R(3), .CW(16)) bus1 ();
    hamming_secded_stream_decoder_if #(.R(3), .CW(2))  bus2 ();
    hamming_secded_stream_decoder_if #(.R(4), .CW(16)) bus3 ();

    hamming_secded_stream_decoder #(.R(3), .CW(16)) dut1 (.clk_i(clk), .rst_i(rst), .strm_io(bus1));
    hamming_secded_stream_decoder #(.R(3), .CW(2))  dut2 (.clk_i(clk), .rst_i(rst), .strm_io(bus2));
    hamming_secded_stream_decoder #(.R(4), .CW(16)) dut3 (.clk_i(clk), .rst_i(rst), .strm_io(bus3));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Main monitor: scoreboard pops, stall stability, in_ready rule, counter model.
    int          m_sec = 0;
    int          m_ded = 0;
    bit          stall = 1'b0;
    logic [7:0]  p_code;
    logic [8:0]  p_rest;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q1.delete();
            m_sec = 0;
            m_ded = 0;
            stall = 1'b0;
        end else begin
            chk("cnt_sec", bus1.cnt_sec, m_sec);
            chk("cnt_ded", bus1.cnt_ded, m_ded);
            chk("in_ready", bus1.in_ready, !(bus1.out_valid && !bus1.out_ready));
            if (stall) begin
                chk("stall_valid", bus1.out_valid, 1);
                chk("stall_code", bus1.out_code, p_code);
                chk("stall_rest", {bus1.out_data, bus1.out_syndrome, bus1.out_sec, bus1.out_ded},
                    p_rest);
            end
            stall  = bus1.out_valid && !bus1.out_ready;
            p_code = bus1.out_code;
            p_rest = {bus1.out_data, bus1.out_syndrome, bus1.out_sec, bus1.out_ded};
            if (bus1.out_valid && bus1.out_ready) begin
                checks++;
                if (q1.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out: got code %0h expected no word", bus1.out_code);
                end else begin
                    e = q1.pop_front();
                    chk("out_code", bus1.out_code, e.code);
                    chk("out_data", bus1.out_data, e.data);
                    chk("out_syndrome", bus1.out_syndrome, e.syn);
                    chk("out_flags", {bus1.out_sec, bus1.out_ded}, {e.sec, e.ded});
                    if (e.chk_lat) chk("latency", cyc - e.cyc, 2);
                    if (e.sec) m_sec++;
                    if (e.ded) m_ded++;
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus3.out_valid) begin
            checks++;
            if (q3.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out3: got code %0h expected no word", bus3.out_code);
            end else begin
                e = q3.pop_front();
                chk("r4_code", bus3.out_code, e.code);
                chk("r4_syndrome", bus3.out_syndrome, e.syn);
                chk("r4_flags", {bus3.out_sec, bus3.out_ded}, {e.sec, e.ded});
                if (e.chk_data) chk("r4_data", bus3.out_data, e.data);
            end
        end
    end

    always @(posedge clk) begin
        if (bp_en) begin
            #1;
            bus1.out_ready = ($urandom_range(0, 2) != 0);
        end
    end

    task automatic send1(input int v, input bit lat, input bit push, input int gap);
        exp_t e;
        bit   acc;
        int   n;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        bus1.in_valid   = 1'b1;
        bus1.in_code    = VCODE[v];
        bus1.correct_en = VCEN[v];
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc   = bus1.in_ready;
            e.cyc = cyc;
            @(posedge clk);
            #1;
            n++;
        end
        bus1.in_valid = 1'b0;
        chk("accept", acc, 1);
        if (acc && push) begin
            e.code     = 16'(VEXC[v]);
            e.data     = 11'(VDAT[v]);
            e.syn      = 4'(VSYN[v]);
            e.sec      = VSEC[v];
            e.ded      = VDED[v];
            e.chk_data = 1'b1;
            e.chk_lat  = lat;
            q1.push_back(e);
        end
    endtask

    task automatic drain1();
        int n = 0;
        while (q1.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain1", q1.size(), 0);
    endtask

    task automatic send2();
        bus2.in_valid   = 1'b1;
        bus2.in_code    = 8'h75;
        bus2.correct_en = 1'b1;
        @(posedge clk);
        #1;
        bus2.in_valid = 1'b0;
    endtask

    task automatic send3(input logic [15:0] w, input logic [15:0] code, input logic [3:0] syn,
                         input bit sec, input logic [10:0] data, input bit chk_data);
        exp_t e;
        bus3.in_valid   = 1'b1;
        bus3.in_code    = w;
        bus3.correct_en = 1'b1;
        @(posedge clk);
        #1;
        e.code     = code;
        e.syn      = syn;
        e.sec      = sec;
        e.ded      = !sec;
        e.data     = data;
        e.chk_data = chk_data;
        e.chk_lat  = 1'b0;
        e.cyc      = 0;
        q3.push_back(e);
        bus3.in_valid = 1'b0;
    endtask

    initial begin
        logic [15:0] one;
        logic [15:0] base;
        int          n;
        one = 16'h1;
        bus1.in_valid = 0; bus1.in_code = 0; bus1.correct_en = 1; bus1.out_ready = 1;
        bus1.clr_cnt = 0;
        bus2.in_valid = 0; bus2.in_code = 0; bus2.correct_en = 1; bus2.out_ready = 1;
        bus2.clr_cnt = 0;
        bus3.in_valid = 0; bus3.in_code = 0; bus3.correct_en = 1; bus3.out_ready = 1;
        bus3.clr_cnt = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", bus1.out_valid, 0);
        chk("rst_out_code", bus1.out_code, 0);
        chk("rst_out_data_syn", {bus1.out_data, bus1.out_syndrome}, 0);
        chk("rst_flags", {bus1.out_sec, bus1.out_ded}, 0);
        chk("rst_in_ready", bus1.in_ready, 1);
        @(posedge clk);
        #1;

        // Directed vectors, back-to-back with a constant ready: latency 2 checked.
        for (int i = 0; i < 8; i++) send1(i, 1'b1, 1'b1, 0);
        drain1();
        @(negedge clk);
        chk("dir_cnt_sec", bus1.cnt_sec, 5);
        chk("dir_cnt_ded", bus1.cnt_ded, 1);
        @(posedge clk);
        #1;

        bp_en = 1'b1;
        for (int i = 0; i < 20; i++) send1(i % 8, 1'b0, 1'b1, $urandom_range(0, 2));
        bp_en = 1'b0;
        @(posedge clk);
        #2;
        bus1.out_ready = 1'b1;
        drain1();
        @(negedge clk);
        chk("strm_cnt_sec", bus1.cnt_sec, 18);
        chk("strm_cnt_ded", bus1.cnt_ded, 3);

        // Two words in flight, then reset: nothing delivered or counted.
        @(posedge clk);
        #1;
        bus1.out_ready = 1'b0;
        send1(1, 1'b0, 1'b0, 0);
        send1(3, 1'b0, 1'b0, 0);
        chk("flight_valid", bus1.out_valid, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", bus1.out_valid, 0);
        chk("mid_rst_cnt", {bus1.cnt_sec, bus1.cnt_ded}, 0);
        chk("mid_rst_code", bus1.out_code, 0);
        chk("mid_rst_in_ready", bus1.in_ready, 1);
        bus1.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_rst_no_word", bus1.out_valid, 0);
        end
        @(posedge clk);
        #1;

        // CW=2 counter: saturation and clear priority.
        for (int i = 0; i < 5; i++) send2();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("sat_cnt_sec", bus2.cnt_sec, 3);
        chk("sat_cnt_ded", bus2.cnt_ded, 0);
        @(posedge clk);
        #1;
        bus2.clr_cnt = 1'b1;
        @(posedge clk);
        #1;
        bus2.clr_cnt = 1'b0;
        @(negedge clk);
        chk("clr_alone", bus2.cnt_sec, 0);
        @(posedge clk);
        #1;
        send2();
        @(posedge clk);
        #1;
        chk("clr_aligned_valid", bus2.out_valid, 1);
        bus2.clr_cnt = 1'b1;
        @(posedge clk);
        #1;
        bus2.clr_cnt = 1'b0;
        @(negedge clk);
        chk("clr_wins", bus2.cnt_sec, 0);
        @(posedge clk);
        #1;
        send2();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("after_clr_inc", bus2.cnt_sec, 1);
        @(posedge clk);
        #1;

        // R=4 exhaustive single/double error sweep on all-zero and all-one codewords.
        for (int b = 0; b < 2; b++) begin
            base = (b == 1) ? 16'hFFFF : 16'h0000;
            for (int i = 0; i < 16; i++) begin
                send3(base ^ (one << i), base, (i == 15) ? 4'd0 : 4'(i + 1), 1'b1,
                      (b == 1) ? 11'h7FF : 11'h000, 1'b1);
            end
            for (int i = 0; i < 15; i++) begin
                for (int j = i + 1; j < 16; j++) begin
                    send3(base ^ (one << i) ^ (one << j), base ^ (one << i) ^ (one << j),
                          4'(i + 1) ^ ((j == 15) ? 4'd0 : 4'(j + 1)), 1'b0, 11'h000, 1'b0);
                end
            end
        end
        n = 0;
        while (q3.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain3", q3.size(), 0);
        chk("q1_empty", q1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hamming_secded_stream_decoder.md
# hamming_secded_stream_decoder

Parametrised, pipelined extended-Hamming (SECDED) decoder with a valid/ready stream interface. It generalises the fixed (7,4) single-error corrector to any R parity bits, adds an overall parity bit for double-error detection, and adds a detect-only mode and saturating error statistics counters. It sits between the channel receiver and the data sink in the error-correction demo datapath.

## Interface
Parameters:
- R, 3, syndrome width; Hamming positions 1..2^R-1.
- N, 2^R (derived, localparam), codeword width including overall parity bit.
- K, 2^R-1-R (derived, localparam), data bits per word.
- CW, 16, width of each statistics counter.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  decoder can accept a word this cycle.
- in_code  in  N  received word; bit p-1 = Hamming position p (p=1..2^R-1); bit N-1 = overall even-parity bit.
- correct_en  in  1  1 = correct single errors; 0 = detect only. Sampled with each accepted word.
- out_valid  out  1  output word valid.
- out_ready  in  1  sink accepts output.
- out_code  out  N  corrected word (uncorrected when out_ded or correct_en=0).
- out_data  out  K  data bits from non-power-of-two positions of out_code, highest position at MSB.
- out_syndrome  out  R  raw syndrome of the word.
- out_sec  out  1  single error detected (corrected if correct_en was 1).
- out_ded  out  1  double error detected, uncorrectable.
- clr_cnt  in  1  synchronous clear of both counters.
- cnt_sec  out  CW  number of out_sec words delivered, saturating.
- cnt_ded  out  CW  number of out_ded words delivered, saturating.

## Operation
- Syndrome s = XOR of position indices p with bit p-1 set (Hamming H-matrix product, mod 2). Parity error pe = XOR of all N bits.
- Classification: s=0, pe=0 -> clean. pe=1 -> single error: s≠0 flips bit s-1; s=0 means error in bit N-1 (flip it). s≠0, pe=0 -> double error: no flip, out_ded=1.
- correct_en=0: out_code = in_code always; out_sec/out_ded still reported.
- out_sec and out_ded are never both 1.
- Counters increment only on output handshake (out_valid & out_ready) with the matching flag; saturate at 2^CW-1; clr_cnt wins over a same-cycle increment (result 0).
- Stage 1 registers in_code, correct_en, s, pe. Stage 2 performs correction/extraction and registers outputs.

## Timing
- Pipeline advance en = out_ready | ~out_valid; in_ready = en (combinational from out_ready/out_valid only, not from in_valid).
- Word accepted when in_valid & in_ready; appears on out_* exactly 2 cycles later if out_ready held high. Throughput 1 word/cycle.
- While en=0 both stages hold; out_* stable while out_valid & ~out_ready.
- Stage valid bits shift on en; bubbles propagate, no reordering, no drops, no duplicates.
- Reset: out_valid=0, stage-1 valid=0, out_code/out_data/out_syndrome=0, out_sec=out_ded=0, cnt_sec=cnt_ded=0. in_ready=1 in the cycle after reset. Reset mid-stream discards in-flight words without counting them.

## Test plan
- R=3, in_code=8'h55, correct_en=1 -> out_code=8'h55, out_data=4'b1011, out_syndrome=0, out_sec=0, out_ded=0, latency 2.
- in_code=8'h75 (position 6 flipped) -> out_code=8'h55, out_data=4'b1011, out_syndrome=3'd6, out_sec=1, cnt_sec +1; with correct_en=0 -> out_code=8'h75, out_sec=1.
- in_code=8'hD5 (parity bit flipped) -> out_syndrome=0, out_sec=1, out_code=8'h55; in_code=8'h74 (positions 6,1) -> out_syndrome=3'd7, out_ded=1, out_data=4'b1111, cnt_ded +1.
- Stream 20 words with random out_ready backpressure and in_valid gaps -> outputs in order, none lost, out_* stable while stalled, in_ready=0 only when out_valid & ~out_ready.
- CW=2: deliver 5 single-error words -> cnt_sec saturates at 3; clr_cnt on a cycle with a delivered error word -> counter reads 0 next cycle.
- Assert rst with two words in flight -> out_valid=0 and counters 0 the next cycle; exhaustive R=4 single- and double-error sweep -> every single error corrected, every double flagged out_ded.
